serial_rx_fifo: RTL and testbench
=================================

Name: serial_rx_fifo

Overview:
- Serial front end for the bus debugger; sits directly upstream of the debug command controller.
- Receives 8N1 asynchronous serial bytes on `rx` and buffers them in a small FIFO.
- Presents buffered bytes through a valid/ready byte stream with an empty flag, which the controller consumes one command/operand byte at a time.
- Flags framing errors and overruns to the host-side logic.

Parameters:
- CLOCKS_PER_BIT, 104, comm_clock cycles per serial bit. Minimum 4.
- FIFO_DEPTH, 16, bytes of buffering. Must be a power of two, at least 2.

Ports:
- comm_clock  input  1  sole clock; all logic on its rising edge.
- comm_reset  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line; idles high.
- out_empty  output  1  high when the FIFO holds zero bytes.
- out_ready  input  1  consumer accepts `out_data` this cycle.
- out_valid  output  1  `out_data` holds the head byte; equals !out_empty.
- out_data  output  8  head-of-FIFO byte (first-word-fall-through); 8'h00 when empty.
- out_count  output  $clog2(FIFO_DEPTH)+1  bytes currently stored.
- framing_error  output  1  sticky; a stop bit was sampled low.
- overrun  output  1  sticky; a byte was dropped because the FIFO was full.
- err_clear  input  1  clears both sticky flags on the next edge.

Behaviour:
- Interface: one clock (comm_clock); reset (comm_reset) is synchronous and active-high.
- Reset:
  - rx synchronizer flops set to 1; receiver state IDLE; bit/clock counters 0.
  - FIFO read/write pointers and count 0.
  - out_empty=1, out_valid=0, out_data=8'h00, out_count=0, framing_error=0, overrun=0.
  - Reset mid-frame abandons the frame; nothing is pushed.
- Input conditioning:
  - rx passes through a 2-flop synchronizer; one further registered copy gives edge detection.
  - Start-of-frame is a high-to-low transition of the synchronized rx. A line held low never retriggers.
- Receiver FSM:
  - IDLE: on a falling edge, load the clock counter and go to START.
  - START: wait CLOCKS_PER_BIT/2 cycles (integer divide), then sample rx.
    - Low: go to DATA with bit index 0.
    - High: glitch; return to IDLE with no flag.
  - DATA: every CLOCKS_PER_BIT cycles sample one bit into the shift register, LSB first. After bit 7 go to STOP.
  - STOP: after CLOCKS_PER_BIT cycles sample rx.
    - High: push the byte.
    - Low: set framing_error and discard the byte.
    - Either way return to IDLE in the same cycle.
- Push rules:
  - Occurs in the stop-sample cycle; out_valid/out_count reflect it on the following cycle (1-cycle latency).
  - Full FIFO with no pop that cycle: byte dropped, overrun set, count unchanged.
  - Full FIFO with a pop that same cycle: push accepted, count stays FIFO_DEPTH.
- Pop rules:
  - Occurs on an edge where out_valid && out_ready; read pointer advances and the next byte appears the following cycle.
  - out_ready while empty has no effect.
  - Simultaneous push and pop on a non-empty FIFO: count unchanged.
  - Push to an empty FIFO during out_ready: no pop that cycle.
- Pointers: log2(FIFO_DEPTH) bits wide, wrap modulo FIFO_DEPTH. Count is tracked separately, range 0..FIFO_DEPTH.
- Sticky flags:
  - Set by their events; cleared by err_clear or reset.
  - A set event in the same cycle as err_clear wins, so the flag stays 1.

Optional Feature:
- Macro: SERIAL_RX_PARITY_EN.
- Defined:
  - Frame is 8E1. A PARITY state between DATA and STOP samples one extra bit after CLOCKS_PER_BIT cycles.
  - If the XOR of the 8 data bits and the parity bit is 1, the byte is discarded at STOP and the extra sticky output `parity_error` (output, 1) is set. err_clear clears it.
  - Framing check still applies; a byte failing both sets both flags.
- Undefined: 8N1; no PARITY state and no parity_error port.

Test Plan:
- CLOCKS_PER_BIT=4, reset held 2 cycles -> all outputs at reset values, out_empty=1; then send 8'hA5 with out_ready=0 -> out_valid=1, out_data=8'hA5, out_count=1 one cycle after the stop sample.
- Send 8'h01, 8'h02, 8'h03 back-to-back, then assert out_ready for 3 cycles -> read 01, 02, 03 in order, then out_empty=1 and out_data=8'h00.
- FIFO_DEPTH=4, send 5 bytes 8'h10..8'h14 with out_ready=0 -> out_count=4, overrun=1, FIFO holds 10..13; err_clear pulse -> overrun=0.
- Stop bit driven low on 8'h55 -> no push, framing_error=1, out_count unchanged; next valid byte 8'h66 received normally.
- 1-cycle low glitch on idle rx -> START rejects it, state returns to IDLE, nothing pushed, no flags; comm_reset asserted during bit 3 of a frame -> no push, FSM IDLE, count 0.
- SERIAL_RX_PARITY_EN defined: send 8'h03 with parity bit 0 -> accepted; with parity bit 1 -> dropped, parity_error=1.

Source files
------------

// File: rtl/serial_rx_fifo.sv
// serial_rx_fifo: asynchronous serial byte receiver feeding a first-word-fall-through
// byte FIFO with a valid/ready output stream and sticky framing/overrun flags.
// Optional feature macro: SERIAL_RX_PARITY_EN (8E1 frames, adds the parity_error output).
module serial_rx_fifo #(
  parameter int CLOCKS_PER_BIT = 104,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic                        comm_clock,
  input  logic                        comm_reset,
  input  logic                        rx,
  output logic                        out_empty,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic [7:0]                  out_data,
  output logic [$clog2(FIFO_DEPTH):0] out_count,
  output logic                        framing_error,
`ifdef SERIAL_RX_PARITY_EN
  output logic                        parity_error,
`endif
  output logic                        overrun,
  input  logic                        err_clear
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 1;
  localparam int CW    = $clog2(CLOCKS_PER_BIT);
  localparam logic [CW-1:0]    BIT_LAST  = CW'(CLOCKS_PER_BIT - 1);
  localparam logic [CW-1:0]    HALF_LAST = CW'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

`ifdef SERIAL_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  // Input conditioning
  logic r_rx_meta, r_rx_sync, r_rx_prev;
  logic w_fall;

  // Receiver
  state_t        r_state, w_state_next;
  logic [CW-1:0] r_clk_cnt, w_clk_cnt_next;
  logic [2:0]    r_bit_idx, w_bit_idx_next;
  logic [7:0]    r_shift, w_shift_next;
  logic          w_push, w_frame_err;
`ifdef SERIAL_RX_PARITY_EN
  logic          r_par, w_par_next;
  logic          w_par_err;
  logic          r_parity_error;
`endif

  // FIFO
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_pop, w_full, w_wr_en, w_drop;

  // Sticky flags
  logic r_framing_error, r_overrun;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection
  always_ff @(posedge comm_clock) begin
    if (comm_reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  assign w_fall = r_rx_prev & ~r_rx_sync;

  // Receiver state and datapath registers
  always_ff @(posedge comm_clock) begin
    if (comm_reset) begin
      r_state   <= S_IDLE;
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
`ifdef SERIAL_RX_PARITY_EN
      r_par     <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_next;
      r_clk_cnt <= w_clk_cnt_next;
      r_bit_idx <= w_bit_idx_next;
      r_shift   <= w_shift_next;
`ifdef SERIAL_RX_PARITY_EN
      r_par     <= w_par_next;
`endif
    end
  end

  // Receiver next-state: mid-bit sampling, LSB-first shift, stop-bit push/error decision
  always_comb begin
    w_state_next   = r_state;
    w_clk_cnt_next = r_clk_cnt + 1'b1;
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    w_push         = 1'b0;
    w_frame_err    = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    w_par_next     = r_par;
    w_par_err      = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        w_clk_cnt_next = '0;
        if (w_fall) w_state_next = S_START;
      end
      S_START: begin
        if (r_clk_cnt == HALF_LAST) begin
          w_clk_cnt_next = '0;
          w_bit_idx_next = '0;
          // A start bit that is already high again was a glitch
          w_state_next   = r_rx_sync ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_clk_cnt == BIT_LAST) begin
          w_clk_cnt_next = '0;
          w_shift_next   = {r_rx_sync, r_shift[7:1]};
          w_bit_idx_next = r_bit_idx + 1'b1;
          if (r_bit_idx == 3'd7) begin
`ifdef SERIAL_RX_PARITY_EN
            w_state_next = S_PARITY;
`else
            w_state_next = S_STOP;
`endif
          end
        end
      end
`ifdef SERIAL_RX_PARITY_EN
      S_PARITY: begin
        if (r_clk_cnt == BIT_LAST) begin
          w_clk_cnt_next = '0;
          w_par_next     = r_rx_sync;
          w_state_next   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (r_clk_cnt == BIT_LAST) begin
          w_clk_cnt_next = '0;
          w_state_next   = S_IDLE;
          w_frame_err    = ~r_rx_sync;
`ifdef SERIAL_RX_PARITY_EN
          w_par_err      = ^{r_shift, r_par};
          w_push         = r_rx_sync & ~w_par_err;
`else
          w_push         = r_rx_sync;
`endif
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // A pop needs a stored byte; a push into a full FIFO survives only if a pop frees a slot
  assign w_pop   = (r_count != '0) & out_ready;
  assign w_full  = (r_count == DEPTH_CNT);
  assign w_wr_en = w_push & (~w_full | w_pop);
  assign w_drop  = w_push & w_full & ~w_pop;

  // Byte storage; only written, never reset
  always_ff @(posedge comm_clock) begin
    if (w_wr_en && !comm_reset) r_mem[r_wr_ptr] <= r_shift;
  end

  // Pointers wrap naturally; count tracks occupancy 0..FIFO_DEPTH
  always_ff @(posedge comm_clock) begin
    if (comm_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky error flags; a new event beats a simultaneous clear
  always_ff @(posedge comm_clock) begin
    if (comm_reset) begin
      r_framing_error <= 1'b0;
      r_overrun       <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      r_parity_error  <= 1'b0;
`endif
    end else begin
      if (w_frame_err)    r_framing_error <= 1'b1;
      else if (err_clear) r_framing_error <= 1'b0;
      if (w_drop)         r_overrun <= 1'b1;
      else if (err_clear) r_overrun <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      if (w_par_err)      r_parity_error <= 1'b1;
      else if (err_clear) r_parity_error <= 1'b0;
`endif
    end
  end

  assign out_empty     = (r_count == '0);
  assign out_valid     = ~out_empty;
  assign out_data      = out_valid ? r_mem[r_rd_ptr] : 8'h00;
  assign out_count     = r_count;
  assign framing_error = r_framing_error;
  assign overrun       = r_overrun;
`ifdef SERIAL_RX_PARITY_EN
  assign parity_error  = r_parity_error;
`endif

endmodule

// File: tb/tb_serial_rx_fifo.sv
// tb_serial_rx_fifo: directed bench for serial_rx_fifo with a byte scoreboard.
// Covers SERIAL_RX_PARITY_EN when that macro is defined for the build.
module tb_serial_rx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       comm_clock = 1'b0;
  logic       comm_reset;
  logic       rx;
  logic       out_ready;
  logic       err_clear;
  logic       out_empty;
  logic       out_valid;
  logic [7:0] out_data;
  logic [2:0] out_count;
  logic       framing_error;
  logic       overrun;
`ifdef SERIAL_RX_PARITY_EN
  logic       parity_error;
  logic       exp_pe;
`endif

  int         vectors     = 0;
  int         miscompares = 0;
  logic [7:0] sb [$];
  logic       exp_fe;
  logic       exp_ov;

  serial_rx_fifo #(
    .CLOCKS_PER_BIT(CPB),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .comm_clock   (comm_clock),
    .comm_reset   (comm_reset),
    .rx           (rx),
    .out_empty    (out_empty),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_count    (out_count),
    .framing_error(framing_error),
`ifdef SERIAL_RX_PARITY_EN
    .parity_error (parity_error),
`endif
    .overrun      (overrun),
    .err_clear    (err_clear)
  );

  always #5 comm_clock = ~comm_clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge comm_clock);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    tick(CPB);
  endtask

  // Drives one full frame and records the expected FIFO/flag effect of its stop sample,
  // which lands on the clock edge right after this task returns.
  task automatic send_frame(input logic [7:0] b, input logic stop_b, input logic par_b);
    logic good;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef SERIAL_RX_PARITY_EN
    send_bit(par_b);
    good = stop_b && ((^b ^ par_b) == 1'b0);
    if ((^b ^ par_b) == 1'b1) exp_pe = 1'b1;
`else
    good = stop_b;
`endif
    send_bit(stop_b);
    if (!stop_b) exp_fe = 1'b1;
    if (good) begin
      if (sb.size() < DEPTH) sb.push_back(b);
      else exp_ov = 1'b1;
    end
    $display("sent byte %02h stop=%0b par=%0b", b, stop_b, par_b);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b1, ^b);
  endtask

  // Compare the FIFO head against the scoreboard (caller handles out_ready and clocking)
  task automatic expect_head();
    logic [7:0] e;
    e = sb.pop_front();
    chk("head_valid", 32'(out_valid), 32'd1);
    chk("head_data", 32'(out_data), 32'(e));
    $display("received byte %02h (expected %02h)", out_data, e);
  endtask

  task automatic drain(input int n);
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      expect_head();
      tick(1);
    end
    out_ready = 1'b0;
  endtask

  task automatic pulse_clear();
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
  endtask

  initial begin
    comm_reset = 1'b1;
    rx         = 1'b1;
    out_ready  = 1'b0;
    err_clear  = 1'b0;
    exp_fe     = 1'b0;
    exp_ov     = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    exp_pe     = 1'b0;
`endif
    tick(2);
    comm_reset = 1'b0;

    // Reset state
    chk("rst_empty", 32'(out_empty), 32'd1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'h00);
    chk("rst_count", 32'(out_count), 32'd0);
    chk("rst_ferr", 32'(framing_error), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
`ifdef SERIAL_RX_PARITY_EN
    chk("rst_perr", 32'(parity_error), 32'd0);
`endif

    // Single byte: visible exactly one cycle after the stop sample
    send_byte(8'hA5);
    chk("a5_before_push", 32'(out_valid), 32'd0);
    tick(1);
    chk("a5_count", 32'(out_count), 32'd1);
    chk("a5_data", 32'(out_data), 32'hA5);
    drain(1);
    chk("a5_empty", 32'(out_empty), 32'd1);

    // Back-to-back frames read out in order
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    tick(1);
    chk("b2b_count", 32'(out_count), 32'(sb.size()));
    drain(3);
    chk("b2b_empty", 32'(out_empty), 32'd1);
    chk("b2b_data_zero", 32'(out_data), 32'h00);
    chk("b2b_count_zero", 32'(out_count), 32'd0);

    // Overrun: fifth byte into a full FIFO is dropped
    for (int i = 0; i < 5; i++) send_byte(8'h10 + 8'(i));
    tick(1);
    chk("ovr_count", 32'(out_count), 32'(DEPTH));
    chk("ovr_flag", 32'(overrun), 32'(exp_ov));
    chk("ovr_ferr", 32'(framing_error), 32'd0);
    pulse_clear();
    exp_ov = 1'b0;
    chk("ovr_cleared", 32'(overrun), 32'(exp_ov));
    chk("ovr_count_kept", 32'(out_count), 32'(DEPTH));
    drain(4);
    chk("ovr_empty", 32'(out_empty), 32'd1);

    // Framing error, with err_clear on the same edge as the set event
    send_frame(8'h55, 1'b0, ^8'h55);
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    chk("ferr_set_wins", 32'(framing_error), 32'(exp_fe));
    chk("ferr_count", 32'(out_count), 32'd0);
    rx = 1'b1;
    tick(8);
    // Push into an empty FIFO while out_ready is high: no pop that cycle
    out_ready = 1'b1;
    send_byte(8'h66);
    tick(1);
    chk("push_empty_count", 32'(out_count), 32'd1);
    expect_head();
    tick(1);
    out_ready = 1'b0;
    chk("push_empty_popped", 32'(out_empty), 32'd1);
    chk("ferr_sticky", 32'(framing_error), 32'd1);
    pulse_clear();
    exp_fe = 1'b0;
    chk("ferr_cleared", 32'(framing_error), 32'(exp_fe));

    // One-cycle glitch is rejected at the start-bit check
    rx = 1'b0;
    tick(1);
    rx = 1'b1;
    tick(12);
    chk("glitch_count", 32'(out_count), 32'd0);
    chk("glitch_ferr", 32'(framing_error), 32'd0);
    chk("glitch_ovr", 32'(overrun), 32'd0);
    send_byte(8'h77);
    tick(1);
    chk("after_glitch_count", 32'(out_count), 32'd1);
    chk("after_glitch_data", 32'(out_data), 32'h77);

    // Reset during data bit 3 abandons the frame and empties the FIFO
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    rx = 1'b1;
    tick(2);
    comm_reset = 1'b1;
    rx         = 1'b1;
    tick(2);
    comm_reset = 1'b0;
    sb.delete();
    tick(12);
    chk("midrst_count", 32'(out_count), 32'd0);
    chk("midrst_empty", 32'(out_empty), 32'd1);
    chk("midrst_data", 32'(out_data), 32'h00);
    send_byte(8'h81);
    tick(1);
    chk("midrst_next_count", 32'(out_count), 32'd1);
    drain(1);

`ifdef SERIAL_RX_PARITY_EN
    // Even parity: correct parity bit accepted, wrong one dropped and flagged
    send_frame(8'h03, 1'b1, 1'b0);
    tick(1);
    chk("par_ok_count", 32'(out_count), 32'd1);
    chk("par_ok_flag", 32'(parity_error), 32'd0);
    send_frame(8'h03, 1'b1, 1'b1);
    tick(1);
    chk("par_bad_count", 32'(out_count), 32'd1);
    chk("par_bad_flag", 32'(parity_error), 32'(exp_pe));
    pulse_clear();
    exp_pe = 1'b0;
    chk("par_cleared", 32'(parity_error), 32'(exp_pe));
    drain(1);
`endif

    chk("final_empty", 32'(out_empty), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
